// File: rtl/spi_frame_tx.sv
// spi_frame_tx: SPI mode-0 frame transmitter.
// Splits a DATA_W-bit word into ceil(DATA_W/8) bytes, zero-padded at the MSB.
// It shifts the bytes MSB-first while ss stays low for the whole frame.
// The full-duplex received bytes appear on rx_data together with the done pulse.
// Optional feature: define SPI_FRAME_CRC_EN to append one check byte after the data
// bytes. The check byte is the XOR of all data bytes. The received check byte is discarded.
module spi_frame_tx #(
    parameter int unsigned DATA_W  = 14,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned GAP_CYC = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [DATA_W-1:0]                 data,
    output logic                              busy,
    output logic                              done,
    output logic [8*((DATA_W + 7) / 8)-1:0]   rx_data,
    output logic                              sclk,
    output logic                              mosi,
    input  logic                              miso,
    output logic                              ss
);

    localparam int unsigned NBYTES = (DATA_W + 7) / 8;
    localparam int unsigned RxW    = 8 * NBYTES;
`ifdef SPI_FRAME_CRC_EN
    localparam int unsigned NB     = NBYTES + 1;
`else
    localparam int unsigned NB     = NBYTES;
`endif
    localparam int unsigned TxW    = 8 * NB;
    localparam int unsigned CntMax = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned ByteW  = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [CntW-1:0]  DivLast  = CntW'(CLK_DIV - 1);
    localparam logic [CntW-1:0]  GapLast  = CntW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [ByteW-1:0] ByteLast = ByteW'(NB - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StGap,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [TxW-1:0]   sh_q, sh_d;
    logic [RxW-1:0]   rx_sh_q, rx_sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [ByteW-1:0] byte_q, byte_d;
    logic             sclk_q, sclk_d;
    logic             mosi_q, mosi_d;
    logic             ss_q, ss_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [RxW-1:0]   rx_data_q, rx_data_d;

    logic [RxW-1:0]   data_pad;
    logic [TxW-1:0]   tx_load;
    logic             rx_en;

    assign data_pad = RxW'(data);

`ifdef SPI_FRAME_CRC_EN
    function automatic logic [7:0] xor_bytes(input logic [RxW-1:0] v);
        logic [7:0] acc;
        acc = '0;
        for (int unsigned i = 0; i < NBYTES; i++) begin
            acc = acc ^ v[8*i +: 8];
        end
        return acc;
    endfunction

    // Check byte rides in the low byte of the shift register, after all data bytes
    assign tx_load = {data_pad, xor_bytes(data_pad)};
    // The check byte is the last one, so its received bits are not kept
    assign rx_en   = (byte_d != ByteLast);
`else
    assign tx_load = data_pad;
    assign rx_en   = 1'b1;
`endif

    // Next-state logic for the frame sequencer and all registered outputs
    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        rx_sh_d   = rx_sh_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ss_d      = ss_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;

        unique case (state_q)
            StIdle: begin
                mosi_d = 1'b0;
                if (start) begin
                    sh_d    = tx_load;
                    rx_sh_d = '0;
                    mosi_d  = tx_load[TxW-1];
                    ss_d    = 1'b0;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    state_d = StSetup;
                end
            end

            StSetup: begin
                if (cnt_q == DivLast) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StShift: begin
                if (cnt_q != DivLast) begin
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the next bit, which may be the next byte's MSB
                        sclk_d = 1'b0;
                        sh_d   = sh_q << 1;
                        mosi_d = sh_q[TxW-2];
                    end else if (bit_q != 3'd7) begin
                        bit_d  = bit_q + 1'b1;
                        sclk_d = 1'b1;
                    end else begin
                        bit_d = '0;
                        if (byte_q == ByteLast) begin
                            state_d = StHold;
                        end else begin
                            byte_d = byte_q + 1'b1;
                            if (GAP_CYC == 0) begin
                                sclk_d = 1'b1;
                            end else begin
                                state_d = StGap;
                            end
                        end
                    end
                end
            end

            StGap: begin
                if (cnt_q == GapLast) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = StShift;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            StHold: begin
                if (cnt_q == DivLast) begin
                    cnt_d     = '0;
                    ss_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // miso is captured at the clock edge that raises sclk
        if (sclk_d && !sclk_q && rx_en) begin
            rx_sh_d = {rx_sh_q[RxW-2:0], miso};
        end
    end

    // State and output registers; reset aborts any frame in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            sh_q      <= '0;
            rx_sh_q   <= '0;
            cnt_q     <= '0;
            bit_q     <= '0;
            byte_q    <= '0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ss_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            rx_sh_q   <= rx_sh_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ss_q      <= ss_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign ss      = ss_q;

endmodule

// File: tb/tb_spi_frame_tx.sv
// tb_spi_frame_tx: scoreboard bench for spi_frame_tx.
// DUT A uses the default configuration. DUT B uses DATA_W=20 with no inter-byte gap.
// Build with SPI_FRAME_CRC_EN defined to exercise the appended check byte.
module tb_spi_frame_tx;

    localparam int DivA = 2;
    localparam int GapA = 2;
    localparam int DwA  = 14;
    localparam int DivB = 2;
    localparam int GapB = 0;
    localparam int DwB  = 20;
`ifdef SPI_FRAME_CRC_EN
    localparam int CrcEn = 1;
`else
    localparam int CrcEn = 0;
`endif

    typedef struct {
        int          t_done;
        int          t_first;
        logic [63:0] rx;
        int          nb;
    } frame_t;

    logic        clk;
    logic        reset;
    logic        start_a, start_b;
    logic [13:0] data_a;
    logic [19:0] data_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [15:0] rx_a;
    logic [23:0] rx_b;
    logic        sclk_a, sclk_b, mosi_a, mosi_b, miso_a, miso_b, ss_a, ss_b;
    logic        loop_a;

    int          cyc;
    int          n_checks;
    int          n_errors;

    frame_t      frm_q[2][$];
    logic [7:0]  byte_q[2][$];
    int          bits_s[2];
    int          rises_s[2];
    int          last_rise_s[2];
    logic [7:0]  sh_s[2];
    logic        sclk_p[2];

    assign miso_a = loop_a ? mosi_a : 1'b0;
    assign miso_b = mosi_b;

    spi_frame_tx #(
        .DATA_W (DwA),
        .CLK_DIV(DivA),
        .GAP_CYC(GapA)
    ) dut_a (
        .clk    (clk),
        .reset  (reset),
        .start  (start_a),
        .data   (data_a),
        .busy   (busy_a),
        .done   (done_a),
        .rx_data(rx_a),
        .sclk   (sclk_a),
        .mosi   (mosi_a),
        .miso   (miso_a),
        .ss     (ss_a)
    );

    spi_frame_tx #(
        .DATA_W (DwB),
        .CLK_DIV(DivB),
        .GAP_CYC(GapB)
    ) dut_b (
        .clk    (clk),
        .reset  (reset),
        .start  (start_b),
        .data   (data_b),
        .busy   (busy_b),
        .done   (done_b),
        .rx_data(rx_b),
        .sclk   (sclk_b),
        .mosi   (mosi_b),
        .miso   (miso_b),
        .ss     (ss_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Queue the expected bytes and the frame-level results for one accepted start
    task automatic push_frame(input int id, input int t, input logic [63:0] d, input int dw,
                              input int div, input int gap, input bit lp);
        int         nbytes;
        int         nb;
        logic [7:0] b;
        logic [7:0] crc;
        frame_t     f;
        nbytes = (dw + 7) / 8;
        nb     = nbytes + CrcEn;
        crc    = 8'h00;
        for (int i = nbytes - 1; i >= 0; i--) begin
            b = d[8*i +: 8];
            byte_q[id].push_back(b);
            crc = crc ^ b;
        end
        if (CrcEn != 0) byte_q[id].push_back(crc);
        f.t_first = t + 1 + div;
        f.t_done  = t + 1 + div + nb * 16 * div + (nb - 1) * gap + div;
        f.rx      = lp ? d : 64'h0;
        f.nb      = nb;
        frm_q[id].push_back(f);
    endtask

    task automatic mon(input int id, input logic sclk, input logic mosi, input logic ss,
                       input logic done, input logic busy, input logic [63:0] rx,
                       input int div, input int gap);
        frame_t f;
        int     pending;
        if (sclk && !sclk_p[id]) begin
            rises_s[id]++;
            check_eq("ss_low_at_edge", 64'(ss), 64'(0));
            if (frm_q[id].size() == 0) begin
                check_eq("edge_without_frame", 64'(frm_q[id].size()), 64'(1));
            end else if (rises_s[id] == 1) begin
                check_eq("first_edge_cycle", 64'(cyc), 64'(frm_q[id][0].t_first));
            end else begin
                check_eq("edge_spacing", 64'(cyc - last_rise_s[id]),
                         64'(((rises_s[id] - 1) % 8 == 0) ? 2 * div + gap : 2 * div));
            end
            last_rise_s[id] = cyc;
            sh_s[id] = {sh_s[id][6:0], mosi};
            bits_s[id]++;
            if (bits_s[id] == 8) begin
                bits_s[id] = 0;
                if (byte_q[id].size() == 0) begin
                    check_eq("extra_byte", 64'(byte_q[id].size()), 64'(1));
                end else begin
                    check_eq("mosi_byte", 64'(sh_s[id]), 64'(byte_q[id].pop_front()));
                end
            end
        end
        sclk_p[id] = sclk;
        if (done) begin
            if (frm_q[id].size() == 0) begin
                check_eq("done_without_frame", 64'(frm_q[id].size()), 64'(1));
            end else begin
                f = frm_q[id].pop_front();
                check_eq("done_cycle", 64'(cyc), 64'(f.t_done));
                check_eq("rx_data", rx, f.rx);
                check_eq("busy_at_done", 64'(busy), 64'(0));
                check_eq("ss_at_done", 64'(ss), 64'(1));
                check_eq("edge_count", 64'(rises_s[id]), 64'(8 * f.nb));
                pending = 0;
                foreach (frm_q[id][k]) pending += frm_q[id][k].nb;
                check_eq("bytes_left", 64'(byte_q[id].size()), 64'(pending));
            end
            rises_s[id] = 0;
            bits_s[id]  = 0;
        end
    endtask

    // Monitor samples on the falling clock edge, away from DUT updates
    always @(negedge clk) begin
        if (reset) begin
            for (int id = 0; id < 2; id++) begin
                frm_q[id].delete();
                byte_q[id].delete();
                bits_s[id]      = 0;
                rises_s[id]     = 0;
                last_rise_s[id] = 0;
                sh_s[id]        = 8'h00;
                sclk_p[id]      = 1'b0;
            end
        end else begin
            mon(0, sclk_a, mosi_a, ss_a, done_a, busy_a, 64'(rx_a), DivA, GapA);
            mon(1, sclk_b, mosi_b, ss_b, done_b, busy_b, 64'(rx_b), DivB, GapB);
        end
    end

    task automatic send_a(input logic [13:0] d, input bit lp);
        loop_a  = lp;
        data_a  = d;
        start_a = 1'b1;
        push_frame(0, cyc, 64'(d), DwA, DivA, GapA, lp);
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check_eq("ss_after_accept", 64'(ss_a), 64'(0));
        check_eq("busy_after_accept", 64'(busy_a), 64'(1));
    endtask

    task automatic wait_drain(input int id, input int max_cyc);
        for (int i = 0; i < max_cyc && frm_q[id].size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("frame_drained", 64'(frm_q[id].size()), 64'(0));
    endtask

    initial begin
        int t;
        int td;
        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        data_a   = '0;
        data_b   = '0;
        loop_a   = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ss", 64'(ss_a), 64'(1));
        check_eq("rst_sclk", 64'(sclk_a), 64'(0));
        check_eq("rst_mosi", 64'(mosi_a), 64'(0));
        check_eq("rst_busy", 64'(busy_a), 64'(0));
        check_eq("rst_done", 64'(done_a), 64'(0));
        check_eq("rst_rx_data", 64'(rx_a), 64'(0));
        check_eq("rst_ss_b", 64'(ss_b), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame, miso tied low
        send_a(14'h2A5C, 1'b0);
        wait_drain(0, 300);

        // Loopback frame
        send_a(14'h3FFF, 1'b1);
        wait_drain(0, 300);

        // A second start mid-frame is ignored and its data is never latched
        send_a(14'h2A5C, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        data_a  = 14'h0001;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        wait_drain(0, 300);
        repeat (100) @(posedge clk);
        #1;
        check_eq("no_second_frame", 64'(busy_a), 64'(0));
        check_eq("no_second_frame_q", 64'(frm_q[0].size()), 64'(0));

        // start held through the done cycle launches the next frame immediately
        loop_a  = 1'b1;
        data_a  = 14'h1234;
        start_a = 1'b1;
        t  = cyc;
        td = t + 1 + 2 * DivA + (((DwA + 7) / 8) + CrcEn) * 16 * DivA
             + (((DwA + 7) / 8) + CrcEn - 1) * GapA;
        push_frame(0, t, 64'(14'h1234), DwA, DivA, GapA, 1'b1);
        push_frame(0, td, 64'(14'h0F0F), DwA, DivA, GapA, 1'b1);
        repeat (td - t - 1) @(posedge clk);
        #1;
        check_eq("ss_before_done", 64'(ss_a), 64'(0));
        @(posedge clk);
        #1;
        check_eq("ss_in_done_cycle", 64'(ss_a), 64'(1));
        check_eq("done_pulse", 64'(done_a), 64'(1));
        data_a = 14'h0F0F;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check_eq("ss_after_done", 64'(ss_a), 64'(0));
        check_eq("busy_after_done", 64'(busy_a), 64'(1));
        wait_drain(0, 400);

        // Reset at the 10th sclk rising edge aborts the frame at once
        send_a(14'h2A5C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        check_eq("sclk_at_edge10", 64'(sclk_a), 64'(1));
        reset = 1'b1;
        #1;
        check_eq("abort_ss", 64'(ss_a), 64'(1));
        check_eq("abort_sclk", 64'(sclk_a), 64'(0));
        check_eq("abort_busy", 64'(busy_a), 64'(0));
        check_eq("abort_done", 64'(done_a), 64'(0));
        check_eq("abort_rx_data", 64'(rx_a), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_a(14'h2A5C, 1'b1);
        wait_drain(0, 300);

        // Wider payload on DUT B, bytes back to back
        data_b  = 20'hABCDE;
        start_b = 1'b1;
        push_frame(1, cyc, 64'(20'hABCDE), DwB, DivB, GapB, 1'b1);
        @(posedge clk);
        #1;
        start_b = 1'b0;
        check_eq("b_busy_after_accept", 64'(busy_b), 64'(1));
        wait_drain(1, 400);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_frame_tx.md
# spi_frame_tx

Parametrised SPI frame transmitter: the next-generation replacement for the fixed 14-bit, two-byte counter sender. It accepts a DATA_W-bit word on a start pulse, splits it into NBYTES = ceil(DATA_W/8) bytes, and shifts them MSB-first under a single slave-select assertion. The SPI mode-0 bit engine is built in, with a programmable SCLK divider and inter-byte gap. It sits between a value source (counter, tick-driven sampler) and the external slave pins, and returns the full-duplex received frame.

## Interface
- DATA_W, 14, payload width (1..64); zero-padded at MSB to 8*NBYTES
- CLK_DIV, 2, clk cycles per SCLK half-period (>=1)
- GAP_CYC, 2, clk cycles between bytes, ss held low, sclk low (>=0)
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high
- start  input  1  request frame; sampled only while busy=0
- data  input  DATA_W  payload, latched on accepted start
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse at frame end
- rx_data  output  8*NBYTES  bytes received on miso; byte0 in MSBs; updated at done
- sclk  output  1  SPI clock, idle low
- mosi  output  1  SPI data out
- miso  input  1  SPI data in
- ss  output  1  slave select, active low

## Operation
- Reset values: ss=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, state IDLE.
- IDLE: start=1 latches padded data into the shift register, then goes to SETUP. Byte0 holds the most significant 8 bits.
- SETUP, CLK_DIV cycles: ss=0, sclk=0, mosi = MSB of current byte.
- SHIFT, 8 bits, each bit is CLK_DIV cycles sclk=1 followed by CLK_DIV cycles sclk=0.
  - miso is sampled on each sclk rising edge.
  - mosi advances to the next bit on each falling edge.
- After bit 0 low half:
  - more bytes remain: go to GAP, or go directly to SHIFT if GAP_CYC=0. mosi = MSB of next byte.
  - no bytes remain: go to HOLD.
- GAP: GAP_CYC cycles, ss=0, sclk=0.
- HOLD: CLK_DIV cycles, ss=0, sclk=0. Next cycle (DONE edge):
  - ss=1, busy=0, done=1.
  - rx_data loads the assembled received bytes.
  - back to IDLE.
- start while busy=1 is ignored; data is not re-latched.
- start sampled in the cycle done=1 is accepted. ss is then high for exactly one cycle between frames.
- Reset mid-frame aborts immediately to reset values. No done pulse; rx_data cleared.
- mosi returns to 0 in IDLE.

## Timing
- Accept cycle = cycle T where start=1 and busy=0. At T+1: ss=0, busy=1.
- First sclk rising edge at T+1+CLK_DIV.
- done at T + 1 + CLK_DIV + NB*16*CLK_DIV + (NB-1)*GAP_CYC + CLK_DIV. NB is the bytes sent.
- For DATA_W=14, CLK_DIV=2, GAP_CYC=2 this is T+71.
- sclk, ss and mosi are registered outputs: no combinational path from start or miso.
- Minimum ss-low-to-first-edge and last-edge-to-ss-high is CLK_DIV cycles each.

## Configuration
- Macro SPI_FRAME_CRC_EN.
- Defined:
  - One check byte equal to the XOR of all NBYTES data bytes is appended after the last data byte, preceded by GAP.
  - NB = NBYTES+1.
  - The received check byte is discarded; rx_data width is unchanged.
- Undefined: NB = NBYTES. No check byte logic is present.

## Test plan
- Defaults, data=14'h2A5C, miso=0:
  - mosi carries 0x2A then 0x5C.
  - 16 sclk rising edges; ss low continuously.
  - 2-cycle gap after edge 8 cycle group.
  - done exactly at T+71; rx_data=16'h0000.
- Loopback miso=mosi, data=14'h3FFF: rx_data=16'h3FFF at done; busy falls the same cycle as done.
- start pulsed again at T+20 with data=14'h0001: ignored, frame still sends 0x2A,0x5C; no second frame.
- start held high in done cycle: ss high for exactly one cycle, then the second frame begins; SETUP is CLK_DIV cycles.
- reset asserted at the 10th sclk rising edge:
  - same cycle: ss=1, sclk=0, busy=0, no done pulse.
  - next start sends the complete frame from byte0.
- SPI_FRAME_CRC_EN defined, data=14'h2A5C: bytes 0x2A,0x5C,0x76; 24 rising edges; done at T+105.
- GAP_CYC=0, DATA_W=20, data=20'hABCDE: bytes 0x0A,0xBC,0xDE back-to-back; done at T+101.
